sevenseg_scan_driver: RTL

- Parametrised, time-multiplexed seven-segment display driver; replaces the fixed 8-digit Anode_Activate/LED_out logic at the top level of the pipelined RISC-V core.
- Displays a register or ALU value as hex digits.
- Adds the following, which the fixed driver lacks:
  - generic digit count and refresh rate
  - selectable output polarity
  - per-digit decimal points
  - leading-zero blanking
  - tear-free, frame-aligned value update.

---
 rtl/sevenseg_pkg.sv | 32 +++
 rtl/hex_to_7seg.sv | 14 +
 rtl/sevenseg_scan_driver.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
// Segment patterns are stored active-high; the driver applies output polarity.
package sevenseg_pkg;

    // Segment bit positions within LED_out: {a,b,c,d,e,f,g} in bits 6..0
    localparam int SEG_A_BIT = 6;
    localparam int SEG_B_BIT = 5;
    localparam int SEG_C_BIT = 4;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 2;
    localparam int SEG_F_BIT = 1;
    localparam int SEG_G_BIT = 0;

    // Active-high pattern with every segment dark
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high hex glyphs 0..F (b and d are lower case)
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    // Width of the digit index; a single-digit display still keeps one bit
    function automatic int idx_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational 4-bit hex to 7-segment decode, active-high segments.
module hex_to_7seg
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the glyph for the selected nibble
    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed seven-segment driver: scans NUM_DIGITS anodes, each lit for
// REFRESH_DIV clocks, with frame-aligned (tear-free) value updates, per-digit
// decimal points, optional leading-zero blanking and selectable polarity.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_en,
    output logic [NUM_DIGITS-1:0]   Anode_Activate,
    output logic [6:0]              LED_out,
    output logic                    dp_out,
    output logic                    frame_start
);

    localparam int                    IDX_W      = idx_width(NUM_DIGITS);
    localparam int                    PRESC_W    = $clog2(REFRESH_DIV);
    localparam logic [PRESC_W-1:0]    PRESC_ZERO = PRESC_W'(0);
    localparam logic [PRESC_W-1:0]    PRESC_ONE  = PRESC_W'(1);
    localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_ZERO   = IDX_W'(0);
    localparam logic [IDX_W-1:0]      IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic                  POL_LOW    = (ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF  = POL_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [6:0]            LED_OFF    = POL_LOW ? ~SEG_BLANK : SEG_BLANK;
    localparam logic                  DP_OFF     = POL_LOW;

    // Scan state
    logic [PRESC_W-1:0]      presc_r;
    logic [IDX_W-1:0]        idx_r;

    // Pending (captured) and displayed data
    logic [4*NUM_DIGITS-1:0] pend_val_r;
    logic [NUM_DIGITS-1:0]   pend_dp_r;
    logic                    pend_valid_r;
    logic [4*NUM_DIGITS-1:0] disp_val_r;
    logic [NUM_DIGITS-1:0]   disp_dp_r;

    // Registered outputs
    logic [NUM_DIGITS-1:0]   anode_r;
    logic [6:0]              led_r;
    logic                    dp_r;
    logic                    frame_start_r;

    // Combinational helpers
    logic                    tick_s;
    logic                    wrap_s;
    logic [NUM_DIGITS-1:0]   onehot_s;
    logic [3:0]              nibble_s;
    logic                    dp_sel_s;
    logic                    lz_sel_s;
    logic [6:0]              seg_dec_s;
    logic [6:0]              seg_lit_s;
    logic [NUM_DIGITS-1:0]   anode_nx_s;
    logic [6:0]              led_nx_s;
    logic                    dp_nx_s;

    assign tick_s = (presc_r == PRESC_LAST);
    assign wrap_s = tick_s && (idx_r == IDX_LAST);

    // Prescaler and digit index; the index advances once per REFRESH_DIV clocks
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= PRESC_ZERO;
            idx_r   <= IDX_ZERO;
        end else if (tick_s) begin
            presc_r <= PRESC_ZERO;
            idx_r   <= wrap_s ? IDX_ZERO : (idx_r + IDX_ONE);
        end else begin
            presc_r <= presc_r + PRESC_ONE;
        end
    end

    // Capture loads into the pending buffer and commit only when the scan wraps,
    // so a frame never shows a mix of old and new digits
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_val_r   <= {(4*NUM_DIGITS){1'b0}};
            pend_dp_r    <= {NUM_DIGITS{1'b0}};
            pend_valid_r <= 1'b0;
            disp_val_r   <= {(4*NUM_DIGITS){1'b0}};
            disp_dp_r    <= {NUM_DIGITS{1'b0}};
        end else if (wrap_s) begin
            if (load) begin
                disp_val_r <= value;
                disp_dp_r  <= dp_in;
            end else if (pend_valid_r) begin
                disp_val_r <= pend_val_r;
                disp_dp_r  <= pend_dp_r;
            end
            pend_valid_r <= 1'b0;
        end else if (load) begin
            pend_val_r   <= value;
            pend_dp_r    <= dp_in;
            pend_valid_r <= 1'b1;
        end
    end

    // Select the current digit's nibble, dp bit and leading-zero status
    always_comb begin : sel_blk
        logic zero_run_v;
        nibble_s   = 4'h0;
        dp_sel_s   = 1'b0;
        lz_sel_s   = 1'b0;
        onehot_s   = {NUM_DIGITS{1'b0}};
        zero_run_v = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run_v  = zero_run_v & (disp_val_r[4*i +: 4] == 4'h0);
            onehot_s[i] = (idx_r == IDX_W'(i));
            nibble_s    = nibble_s | ({4{onehot_s[i]}} & disp_val_r[4*i +: 4]);
            dp_sel_s    = dp_sel_s | (onehot_s[i] & disp_dp_r[i]);
            lz_sel_s    = lz_sel_s | (onehot_s[i] & zero_run_v);
        end
    end

    hex_to_7seg u_dec (
        .nibble (nibble_s),
        .seg    (seg_dec_s)
    );

    // Apply leading-zero blanking (never on digit 0) and output polarity
    always_comb begin
        seg_lit_s = seg_dec_s;
        if (blank_en && (idx_r != IDX_ZERO) && lz_sel_s) begin
            seg_lit_s = SEG_BLANK;
        end else begin
            seg_lit_s = seg_dec_s;
        end
        if (POL_LOW) begin
            anode_nx_s = ~onehot_s;
            led_nx_s   = ~seg_lit_s;
            dp_nx_s    = ~dp_sel_s;
        end else begin
            anode_nx_s = onehot_s;
            led_nx_s   = seg_lit_s;
            dp_nx_s    = dp_sel_s;
        end
    end

    // Output registers; frame_start marks the first output cycle of digit 0
    always_ff @(posedge clk) begin
        if (rst) begin
            anode_r       <= ANODE_OFF;
            led_r         <= LED_OFF;
            dp_r          <= DP_OFF;
            frame_start_r <= 1'b0;
        end else begin
            anode_r       <= anode_nx_s;
            led_r         <= led_nx_s;
            dp_r          <= dp_nx_s;
            frame_start_r <= (presc_r == PRESC_ZERO) && (idx_r == IDX_ZERO);
        end
    end

    assign Anode_Activate = anode_r;
    assign LED_out        = led_r;
    assign dp_out         = dp_r;
    assign frame_start    = frame_start_r;

endmodule
